// File: rtl/int_to_float_axis_pipe.sv
// int_to_float_axis_pipe
// Converts an IN_WIDTH-bit integer (signed or unsigned) to an IEEE-754
// single-precision float through a three-stage AXI-Stream pipeline.
//   S1: sign and magnitude
//   S2: leading-one position and left-normalised magnitude
//   S3: rounded and packed result (this stage drives the m_axis outputs)
// All stages advance together when the output register is empty or is
// being drained.
// Optional build macro INT_TO_FLOAT_ROUND_NEAREST_EN:
//   defined   -> round-to-nearest-even using a guard bit and a sticky bit
//   undefined -> truncate toward zero, with no rounding logic
module int_to_float_axis_pipe #(
  parameter int IN_WIDTH = 32,
  parameter int SIGNED   = 1
) (
  input  logic                aclk,
  input  logic                rst,
  input  logic [IN_WIDTH-1:0] s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic                s_axis_tlast,
  output logic [31:0]         m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast
);

  logic adv;

  logic                s1_valid;
  logic                s1_last;
  logic                s1_sign;
  logic [IN_WIDTH-1:0] s1_mag;

  logic        s2_valid;
  logic        s2_last;
  logic        s2_sign;
  logic [4:0]  s2_pos;
  logic [31:0] s2_norm;

  logic                s1_sign_d;
  logic [IN_WIDTH-1:0] s1_mag_d;
  logic [31:0]         mag32;
  logic [4:0]          lead_pos;
  logic [31:0]         norm_d;
  logic [7:0]          exp_base;
  logic [7:0]          exp_d;
  logic [22:0]         frac_d;
  logic [31:0]         result_d;

  // The whole pipeline moves only when the output slot is free or being taken.
  assign adv           = ~m_axis_tvalid | m_axis_tready;
  assign s_axis_tready = adv;

  // Split the operand into sign and magnitude; the most negative value maps to 2^(IN_WIDTH-1).
  always_comb begin
    s1_sign_d = 1'b0;
    s1_mag_d  = s_axis_tdata;
    if ((SIGNED != 0) && s_axis_tdata[IN_WIDTH-1]) begin
      s1_sign_d = 1'b1;
      s1_mag_d  = ~s_axis_tdata + IN_WIDTH'(1);
    end
  end

  // Stage 1 register: sign, magnitude, valid and frame marker.
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_sign  <= 1'b0;
      s1_mag   <= '0;
    end else if (adv) begin
      s1_valid <= s_axis_tvalid;
      s1_last  <= s_axis_tlast;
      s1_sign  <= s1_sign_d;
      s1_mag   <= s1_mag_d;
    end
  end

  // Find the most significant one and shift it up to bit 31.
  always_comb begin
    mag32    = 32'(s1_mag);
    lead_pos = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (mag32[i]) begin
        lead_pos = 5'(i);
      end
    end
    norm_d = mag32 << (5'd31 - lead_pos);
  end

  // Stage 2 register: leading-one position and normalised magnitude; bit 31 clear means zero input.
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_sign  <= 1'b0;
      s2_pos   <= 5'd0;
      s2_norm  <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_sign  <= s1_sign;
      s2_pos   <= lead_pos;
      s2_norm  <= norm_d;
    end
  end

  assign exp_base = 8'd127 + {3'b000, s2_pos};

`ifdef INT_TO_FLOAT_ROUND_NEAREST_EN
  logic        guard_bit;
  logic        sticky_bit;
  logic        round_up;
  logic [24:0] mant_sum;

  // Round to nearest even; a carry out of the mantissa bumps the exponent.
  always_comb begin
    guard_bit  = s2_norm[7];
    sticky_bit = |s2_norm[6:0];
    round_up   = guard_bit & (sticky_bit | s2_norm[8]);
    mant_sum   = {1'b0, s2_norm[31:8]} + 25'(round_up);
    exp_d      = exp_base;
    frac_d     = mant_sum[22:0];
    if (mant_sum[24]) begin
      exp_d  = exp_base + 8'd1;
      frac_d = 23'd0;
    end
  end
`else
  logic trunc_unused;
  assign trunc_unused = ^s2_norm[7:0];

  // Truncate toward zero: the fraction is simply the 23 bits below the leading one.
  always_comb begin
    exp_d  = exp_base;
    frac_d = s2_norm[30:8];
  end
`endif

  // Pack the result; a zero magnitude always gives +0.
  always_comb begin
    result_d = {s2_sign, exp_d, frac_d};
    if (!s2_norm[31]) begin
      result_d = 32'h0000_0000;
    end
  end

  // Stage 3 register drives the output stream and holds it while stalled.
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= 32'h0000_0000;
    end else if (adv) begin
      m_axis_tvalid <= s2_valid;
      m_axis_tlast  <= s2_last;
      m_axis_tdata  <= result_d;
    end
  end

endmodule

// File: doc/int_to_float_axis_pipe.md
INT_TO_FLOAT_AXIS_PIPE -- requirements
Module: int_to_float_axis_pipe

Interface
REQ-001 Parameter IN_WIDTH, default 32, integer input width; legal range 8..32.
REQ-002 Parameter SIGNED, default 1; 1 = two's-complement input, 0 = unsigned input.
REQ-003 aclk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 s_axis_tdata  input  IN_WIDTH  integer operand.
REQ-006 s_axis_tvalid  input  1  operand valid.
REQ-007 s_axis_tready  output  1  block accepts operand.
REQ-008 s_axis_tlast  input  1  frame marker, passed through unchanged.
REQ-009 m_axis_tdata  output  32  IEEE-754 single-precision result.
REQ-010 m_axis_tvalid  output  1  result valid.
REQ-011 m_axis_tready  input  1  downstream accepts result.
REQ-012 m_axis_tlast  output  1  tlast of the operand that produced this result.

Function
REQ-013 Operand accepted on a cycle with s_axis_tvalid && s_axis_tready high.
REQ-014 Three-stage pipeline: S1 registers sign and magnitude; S2 registers leading-one position and left-normalised magnitude; S3 registers rounded, packed result.
REQ-015 Global advance enable adv = ~m_axis_tvalid | m_axis_tready; all stages and valid bits shift only when adv = 1.
REQ-016 s_axis_tready = adv, combinationally; no other combinational input-to-output path.
REQ-017 Latency: result presented exactly 3 cycles after acceptance when adv stays high; stalls add cycles 1:1.
REQ-018 Throughput one result per cycle with m_axis_tready held high.
REQ-019 While m_axis_tvalid && ~m_axis_tready, m_axis_tdata and m_axis_tlast hold stable.
REQ-020 Sign: SIGNED=1 -> sign = MSB, magnitude = |x| as IN_WIDTH-bit unsigned (most negative value yields 2^(IN_WIDTH-1)); SIGNED=0 -> sign 0, magnitude = x.
REQ-021 Zero input -> 32'h00000000 (+0), never -0.
REQ-022 Exponent = 127 + p, p = index of most significant 1 of magnitude; fraction = next 23 bits below it, zero-filled.
REQ-023 Bits below the 23-bit fraction feed the rounding rule of REQ-030; for IN_WIDTH <= 24 results are exact.
REQ-024 Mantissa round carry-out (e.g. unsigned 0xFFFFFFFF) -> fraction 0, exponent + 1.
REQ-025 tlast travels in lock-step with its operand through all three stages.
REQ-026 Bubbles (valid = 0 slots) propagate; the pipeline does not compress them.

Reset
REQ-027 rst high clears all stage valid bits immediately; m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tlast = 0.
REQ-028 Reset mid-operation discards all in-flight operands; none emerge after rst deasserts.
REQ-029 First acceptance allowed on the first rising edge after rst deasserts (s_axis_tready = 1 then, since m_axis_tvalid = 0).

Configuration
REQ-030 Macro INT_TO_FLOAT_ROUND_NEAREST_EN defined -> round-to-nearest-even via guard bit and sticky OR of remaining bits; undefined -> truncate (round toward zero), rounding logic absent.
REQ-031 Latency and handshake identical with or without the macro.

Verification
REQ-032 SIGNED=1: inputs 1, -1, 0, 32'h80000000 back-to-back, m_axis_tready=1 -> 3F800000, BF800000, 00000000, CF000000 on four consecutive cycles, first 3 cycles after first acceptance.
REQ-033 Macro defined: 16777217 -> 4B800000 (tie to even); 16777219 -> 4B800002; SIGNED=0, 32'hFFFFFFFF -> 4F800000.
REQ-034 Macro undefined: 16777219 -> 4B800001; SIGNED=0, 32'hFFFFFFFF -> 4F7FFFFF.
REQ-035 Stream 10 operands 1..10 with tlast on the 10th, m_axis_tready toggled pseudo-randomly -> ten results 3F800000..41200000 in order, none dropped/duplicated, tlast only on 41200000, data stable during stalls.
REQ-036 Assert rst for one cycle with three operands in flight -> m_axis_tvalid = 0 immediately, no stale result afterwards; next operand 5 -> 40A00000 after 3 cycles.
REQ-037 IN_WIDTH=16, SIGNED=1: 16'h8000 -> C7000000; 16'h7FFF -> 46FFFE00.
